// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - shared iterative shift-add multiplier controller for two issue lanes
//
// Purpose: arbitrates multiply requests from lane 1 and lane 2 with round-robin
// tie-breaking, runs one shift-add iteration per cycle, stalls each requesting
// lane until its own product is presented, and returns the product with its
// destination register and lane tag.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous reset, active HIGH (legacy name)
//   i_Req1/i_Req2    lane multiply request
//   i_A1/i_A2        lane multiplicand
//   i_B1/i_B2        lane multiplier
//   i_Rd1/i_Rd2      lane destination register
//   i_Flush          kill any in-flight multiply, block new grants
//   o_Stall1/2       hold the corresponding lane pipeline registers
//   o_Valid          one-cycle product strobe
//   o_Result         low DW bits of A*B (held until the next product)
//   o_WA             destination register of the product
//   o_Lane           0 = lane 1, 1 = lane 2
//   o_Busy           controller not idle

`ifndef D_WIDTH
`define D_WIDTH 32
`endif

module mul_share_ctrl #(
  parameter int DW = `D_WIDTH,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_Req1,
  input  logic [DW-1:0] i_A1,
  input  logic [DW-1:0] i_B1,
  input  logic [3:0]    i_Rd1,
  input  logic          i_Req2,
  input  logic [DW-1:0] i_A2,
  input  logic [DW-1:0] i_B2,
  input  logic [3:0]    i_Rd2,
  input  logic          i_Flush,
  output logic          o_Stall1,
  output logic          o_Stall2,
  output logic          o_Valid,
  output logic [DW-1:0] o_Result,
  output logic [3:0]    o_WA,
  output logic          o_Lane,
  output logic          o_Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] acc;
  logic [DW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic [3:0]    wa;
  logic          lane;
  logic          rr_ptr;
  logic          valid_r;

  logic          grant;
  logic          grant_lane;
  logic [DW-1:0] acc_next;

  // Arbitration: a single requester wins outright; on a tie rr_ptr picks.
  always_comb begin
    grant      = 1'b0;
    grant_lane = 1'b0;
    if (state == IDLE && !i_Flush) begin
      if (i_Req1 && i_Req2) begin
        grant      = 1'b1;
        grant_lane = rr_ptr;
      end else if (i_Req1) begin
        grant      = 1'b1;
        grant_lane = 1'b0;
      end else if (i_Req2) begin
        grant      = 1'b1;
        grant_lane = 1'b1;
      end
    end
  end

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      wa       <= '0;
      lane     <= 1'b0;
      rr_ptr   <= 1'b0;
      valid_r  <= 1'b0;
      o_Result <= '0;
      o_WA     <= '0;
      o_Lane   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            mcand  <= grant_lane ? i_A2  : i_A1;
            mplier <= grant_lane ? i_B2  : i_B1;
            wa     <= grant_lane ? i_Rd2 : i_Rd1;
            lane   <= grant_lane;
            acc    <= '0;
            cnt    <= '0;
            rr_ptr <= ~grant_lane;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (i_Flush) begin
            state <= IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST_CNT) begin
              // Product registers are only touched here so they hold between products.
              state    <= DONE;
              valid_r  <= 1'b1;
              o_Result <= acc_next;
              o_WA     <= wa;
              o_Lane   <= lane;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A flush arriving in DONE must suppress the write-back in that same cycle.
  assign o_Valid  = valid_r & ~i_Flush;
  assign o_Busy   = (state != IDLE);
  assign o_Stall1 = i_Req1 & ~((state == DONE) & (lane == 1'b0) & ~i_Flush);
  assign o_Stall2 = i_Req2 & ~((state == DONE) & (lane == 1'b1) & ~i_Flush);

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Controller for a single iterative shift-add multiplier shared by the two issue lanes (lane 1 and lane 2) of the dual-issue EXE stage.
- Arbitrates multiply requests from both lanes using round-robin priority.
- Stalls a requesting lane until its product is ready.
- Returns the product with its destination register and lane tag for the MEM-stage write-back path.

Parameters:
- DW, `D_WIDTH (32): operand/result width; also the number of iteration cycles.
- CW, 6: iteration counter width; must satisfy 2^CW > DW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-high: asserted when 1, despite the codebase port name.
- i_Req1  in  1  lane 1 has a valid multiply in EXE.
- i_A1  in  DW  lane 1 multiplicand (post-forwarding SrcA).
- i_B1  in  DW  lane 1 multiplier (post-forwarding SrcB).
- i_Rd1  in  4  lane 1 destination register.
- i_Req2  in  1  lane 2 request.
- i_A2  in  DW  lane 2 multiplicand.
- i_B2  in  DW  lane 2 multiplier.
- i_Rd2  in  4  lane 2 destination register.
- i_Flush  in  1  branch-taken flush; kills any in-flight multiply.
- o_Stall1  out  1  hold lane 1 pipeline registers.
- o_Stall2  out  1  hold lane 2 pipeline registers.
- o_Valid  out  1  product valid, one-cycle pulse.
- o_Result  out  DW  low DW bits of A*B.
- o_WA  out  4  destination register of the product.
- o_Lane  out  1  0 = lane 1, 1 = lane 2.
- o_Busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst_n=1, any time, including mid-operation):
  - state=IDLE, cnt=0, acc=0, mcand=0, mplier=0.
  - o_Valid=0, o_Result=0, o_WA=0, o_Lane=0.
  - rr_ptr=0, meaning lane 1 wins the next tie.
- IDLE:
  - If i_Flush=1: no grant; stay IDLE.
  - Else if exactly one i_Req is high: grant that lane.
  - If both are high: grant the lane selected by rr_ptr.
  - On grant (clock edge):
    - Capture mcand=A, mplier=B, wa=Rd, lane.
    - acc=0, cnt=0, state to BUSY.
    - rr_ptr is set to point at the other lane.
- BUSY, one iteration per cycle:
  - If mplier[0] then acc += mcand (mod 2^DW).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt==DW-1 the final step is performed and state goes to DONE.
- DONE:
  - o_Valid=1, o_Result=acc, o_WA=wa, o_Lane=lane.
  - Next cycle: IDLE, o_Valid=0.
  - o_Result, o_WA and o_Lane hold their values until the next DONE.
- Latency: request first seen in IDLE at cycle T; o_Valid=1 in cycle T+DW+1. Back-to-back throughput is one product per DW+2 cycles.
- Stall logic is combinational:
  - o_Stall1 = i_Req1 & ~(state==DONE & lane==0 & ~i_Flush).
  - o_Stall2 is the same with lane==1.
  - A losing lane stays stalled through the winner's whole operation.
- Requester contract:
  - Keep i_Req, A, B and Rd stable while stalled.
  - Operands are sampled only at grant; later changes are ignored.
  - In the cycle after an unstalled DONE, i_Req reflects the next instruction.
- Flush:
  - i_Flush=1 in BUSY or DONE: next state IDLE, o_Valid forced 0 that cycle, no write-back.
  - rr_ptr is not restored.
- Arithmetic: unsigned shift-add; the result is the low DW bits of the product, identical for signed two's-complement operands. No flags are produced.
- o_Valid never asserts without a preceding grant. Only one operation is in flight at a time.

Test Plan:
- Reset, then i_Req1=1, A1=7, B1=6, Rd1=3 at cycle T:
  - o_Valid=1 at T+33 (DW=32), o_Result=42, o_WA=3, o_Lane=0.
  - o_Stall1=1 in T..T+32 and 0 at T+33.
- Both lanes request at the same time after reset (A1=3,B1=5; A2=10,B2=10):
  - Lane 1 is served first with result 15.
  - Lane 2 stays stalled until its own DONE 34 cycles later, result 100, o_Lane=1.
- Both lanes request again with rr_ptr pointing at lane 2 → lane 2 is granted first.
- Lane 1 requests A1=0xFFFFFFFF, B1=2 → o_Result=0xFFFFFFFE (wrap-around).
- Lane 1 requests A1=0x80000000, B1=0x80000000 → o_Result=0.
- i_Flush=1 at BUSY cycle 10:
  - Next cycle state=IDLE and o_Valid stays 0 for the whole window.
  - A new request issued afterwards completes normally after DW+1 cycles.
- rst_n=1 asserted mid-BUSY (asynchronous, between clock edges):
  - All outputs go to 0 immediately.
  - After release, a lane 2 request with A2=9, B2=9 returns 81.
